stream_demux: RTL and testbench

- Registered 1-to-N stream demultiplexer, the routing counterpart of the 2:1 selector used in the ALU datapath.
- Takes one valid/ready input stream and forwards each accepted word to the output channel named by its accompanying select field.
- Each output channel has a one-entry holding register, so back-pressure on one channel never corrupts another.
- Sits between the ALU result bus and per-unit consumers (writeback, flags, debug).

---
 rtl/stream_demux.sv | 127 ++++++++++++
 tb/tb_stream_demux.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/stream_demux.sv
// -----------------------------------------------------------------------------
// stream_demux
//   Registered 1-to-N stream demultiplexer. Each word accepted on the single
//   valid/ready input is forwarded to the output channel named by in_select.
//   Every channel owns a one-entry holding register, so a stalled consumer
//   only blocks words aimed at its own channel. A word whose select is out of
//   range is accepted and dropped, and this sets the sticky sel_err flag.
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous, active-high reset
//   in_valid   input word and select are valid
//   in_ready   block accepts the input word this cycle (combinational)
//   in_data    input word, WIDTH bits
//   in_select  target channel index, SEL_W bits
//   out_valid  bit k: channel k holds a word
//   out_ready  bit k: consumer k takes the word this cycle
//   out_data   channel k word at bits [k*WIDTH +: WIDTH]
//   sel_err    sticky: an out-of-range select was accepted
// -----------------------------------------------------------------------------
module stream_demux #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 4,
  parameter int SEL_W    = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [WIDTH-1:0]          in_data,
  input  logic [SEL_W-1:0]          in_select,
  output logic [CHANNELS-1:0]       out_valid,
  input  logic [CHANNELS-1:0]       out_ready,
  output logic [CHANNELS*WIDTH-1:0] out_data,
  output logic                      sel_err
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } ch_state_e;

  ch_state_e                           state_q [CHANNELS];
  ch_state_e                           state_d [CHANNELS];
  logic [CHANNELS-1:0][WIDTH-1:0]      data_q;
  logic [CHANNELS-1:0][WIDTH-1:0]      data_d;
  logic                                sel_err_q;
  logic                                sel_err_d;

  logic [31:0]                         sel_ext;
  logic                                sel_oor;
  logic [CHANNELS-1:0]                 sel_hit;
  logic [CHANNELS-1:0]                 full;
  logic [CHANNELS-1:0]                 accept;
  logic                                in_ready_c;

  always_comb begin
    for (int k = 0; k < CHANNELS; k++) begin
      full[k] = (state_q[k] == FULL);
    end
  end

  // Select decode is done on a 32-bit copy so that selects beyond CHANNELS
  // (possible whenever CHANNELS < 2**SEL_W) match no channel at all.
  always_comb begin
    sel_ext = 32'(in_select);
    sel_oor = (sel_ext >= 32'(CHANNELS));
    sel_hit = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      sel_hit[k] = (sel_ext == 32'(k));
    end
    // A full channel can still take a word when its consumer drains in the
    // same cycle; out-of-range words are always taken (and dropped).
    in_ready_c = sel_oor | (|(sel_hit & (~full | out_ready)));
  end

  always_comb begin
    accept    = sel_hit & {CHANNELS{in_valid & in_ready_c}};
    sel_err_d = sel_err_q | (in_valid & in_ready_c & sel_oor);
    data_d    = data_q;
    for (int k = 0; k < CHANNELS; k++) begin
      state_d[k] = state_q[k];
      case (state_q[k])
        EMPTY: begin
          if (accept[k]) begin
            state_d[k] = FULL;
          end
        end
        FULL: begin
          // Simultaneous drain and accept keeps the channel FULL with the
          // new word replacing the old one.
          if (!accept[k] && out_ready[k]) begin
            state_d[k] = EMPTY;
          end
        end
        default: state_d[k] = EMPTY;
      endcase
      // Data is only loaded on accept, so it stays stable under
      // back-pressure and keeps its last value after a drain.
      if (accept[k]) begin
        data_d[k] = in_data;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < CHANNELS; k++) begin
        state_q[k] <= EMPTY;
      end
      data_q    <= '0;
      sel_err_q <= 1'b0;
    end else begin
      for (int k = 0; k < CHANNELS; k++) begin
        state_q[k] <= state_d[k];
      end
      data_q    <= data_d;
      sel_err_q <= sel_err_d;
    end
  end

  assign in_ready  = in_ready_c;
  assign out_valid = full;
  assign out_data  = data_q;
  assign sel_err   = sel_err_q;

endmodule

// File: tb/tb_stream_demux.sv
// -----------------------------------------------------------------------------
// tb_stream_demux
//   Directed bench for stream_demux. Instance u_dut uses the default four
//   channels; u_dut3 uses CHANNELS = 3 so that select 3 is out of range.
//   Inputs change just after clock edges; outputs are sampled 1 ns later.
// -----------------------------------------------------------------------------
module tb_stream_demux;

  logic        clk;
  logic        rst;

  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_data;
  logic [1:0]  in_select;
  logic [3:0]  out_valid;
  logic [3:0]  out_ready;
  logic [31:0] out_data;
  logic        sel_err;

  logic        in_valid3;
  logic        in_ready3;
  logic [7:0]  in_data3;
  logic [1:0]  in_select3;
  logic [2:0]  out_valid3;
  logic [2:0]  out_ready3;
  logic [23:0] out_data3;
  logic        sel_err3;

  int nvec;
  int nmis;

  stream_demux #(.WIDTH(8), .CHANNELS(4), .SEL_W(2)) u_dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_select (in_select),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .sel_err   (sel_err)
  );

  stream_demux #(.WIDTH(8), .CHANNELS(3), .SEL_W(2)) u_dut3 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid3),
    .in_ready  (in_ready3),
    .in_data   (in_data3),
    .in_select (in_select3),
    .out_valid (out_valid3),
    .out_ready (out_ready3),
    .out_data  (out_data3),
    .sel_err   (sel_err3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_vec(input string tag, input logic [31:0] obs,
                           input logic [31:0] exp);
    nvec++;
    if (obs !== exp) begin
      nmis++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic edge_sample();
    @(posedge clk);
    #1;
  endtask

  initial begin
    nvec       = 0;
    nmis       = 0;
    rst        = 1'b1;
    in_valid   = 1'b0;
    in_data    = 8'h00;
    in_select  = 2'd0;
    out_ready  = 4'b0000;
    in_valid3  = 1'b0;
    in_data3   = 8'h00;
    in_select3 = 2'd0;
    out_ready3 = 3'b000;

    // Reset state
    #12;
    check_vec("rst_out_valid", 32'(out_valid), 32'h0);
    check_vec("rst_out_data", out_data, 32'h0);
    check_vec("rst_sel_err", 32'(sel_err), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    edge_sample();

    // Basic route: 0xA5 to channel 1 with every consumer stalled
    in_valid  = 1'b1;
    in_data   = 8'hA5;
    in_select = 2'd1;
    #1;
    check_vec("route_in_ready_empty", 32'(in_ready), 32'h1);
    edge_sample();
    check_vec("route_out_valid", 32'(out_valid), 32'h2);
    check_vec("route_data_ch1", 32'(out_data[15:8]), 32'hA5);
    check_vec("route_in_ready_sel1", 32'(in_ready), 32'h0);
    in_select = 2'd0;
    #1;
    check_vec("route_in_ready_sel0", 32'(in_ready), 32'h1);
    in_valid = 1'b0;

    // Back-pressure: 0x3C held in channel 3 for five cycles
    in_valid  = 1'b1;
    in_data   = 8'h3C;
    in_select = 2'd3;
    edge_sample();
    in_valid = 1'b0;
    check_vec("bp_out_valid", 32'(out_valid), 32'hA);
    for (int i = 0; i < 5; i++) begin
      edge_sample();
      check_vec("bp_hold_data_ch3", 32'(out_data[31:24]), 32'h3C);
      check_vec("bp_in_ready_sel3", 32'(in_ready), 32'h0);
    end
    // Drain and refill channel 3 in the same cycle
    out_ready = 4'b1000;
    in_valid  = 1'b1;
    in_data   = 8'h77;
    #1;
    check_vec("bp_in_ready_drain", 32'(in_ready), 32'h1);
    edge_sample();
    in_valid  = 1'b0;
    out_ready = 4'b0000;
    check_vec("bp_refill_valid", 32'(out_valid), 32'hA);
    check_vec("bp_refill_data_ch3", 32'(out_data[31:24]), 32'h77);
    // Drain everything; data fields keep their last words
    out_ready = 4'b1111;
    edge_sample();
    check_vec("drain_out_valid", 32'(out_valid), 32'h0);
    check_vec("drain_keep_data", out_data, 32'h7700A500);

    // Streaming 0x01..0x08 into channel 0 with all consumers ready
    for (int i = 1; i <= 8; i++) begin
      in_valid  = 1'b1;
      in_data   = 8'(i);
      in_select = 2'd0;
      #1;
      check_vec("stream_in_ready", 32'(in_ready), 32'h1);
      edge_sample();
      check_vec("stream_valid_ch0", 32'(out_valid), 32'h1);
      check_vec("stream_data_ch0", 32'(out_data[7:0]), 32'(i));
    end
    in_valid = 1'b0;
    edge_sample();
    check_vec("stream_drained", 32'(out_valid), 32'h0);

    // Concurrent channels: fill 0 and 2, then drain 0 while refilling 2
    out_ready = 4'b0000;
    in_valid  = 1'b1;
    in_data   = 8'h11;
    in_select = 2'd0;
    edge_sample();
    in_data   = 8'h22;
    in_select = 2'd2;
    edge_sample();
    in_valid = 1'b0;
    check_vec("conc_filled", 32'(out_valid), 32'h5);
    check_vec("conc_data_ch0", 32'(out_data[7:0]), 32'h11);
    check_vec("conc_data_ch2", 32'(out_data[23:16]), 32'h22);
    out_ready = 4'b0101;
    in_valid  = 1'b1;
    in_data   = 8'h33;
    in_select = 2'd2;
    #1;
    check_vec("conc_in_ready", 32'(in_ready), 32'h1);
    edge_sample();
    in_valid  = 1'b0;
    out_ready = 4'b0000;
    check_vec("conc_out_valid", 32'(out_valid), 32'h4);
    check_vec("conc_new_ch2", 32'(out_data[23:16]), 32'h33);
    check_vec("conc_keep_ch0", 32'(out_data[7:0]), 32'h11);

    // Bad select on the three-channel instance
    in_valid3  = 1'b1;
    in_data3   = 8'h5A;
    in_select3 = 2'd1;
    edge_sample();
    check_vec("bad_pre_valid", 32'(out_valid3), 32'h2);
    in_data3   = 8'hFF;
    in_select3 = 2'd3;
    #1;
    check_vec("bad_in_ready", 32'(in_ready3), 32'h1);
    check_vec("bad_sel_err_before", 32'(sel_err3), 32'h0);
    edge_sample();
    check_vec("bad_out_valid", 32'(out_valid3), 32'h2);
    check_vec("bad_sel_err", 32'(sel_err3), 32'h1);
    check_vec("bad_data_untouched", 32'(out_data3), 32'h005A00);
    in_data3   = 8'h01;
    in_select3 = 2'd0;
    edge_sample();
    in_valid3 = 1'b0;
    edge_sample();
    check_vec("bad_sticky", 32'(sel_err3), 32'h1);
    check_vec("bad_after_valid", 32'(out_valid3), 32'h3);
    check_vec("good_sel_err_clear", 32'(sel_err), 32'h0);

    // Asynchronous reset mid-stream with channel 2 full
    check_vec("midrst_pre_valid", 32'(out_valid), 32'h4);
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    check_vec("midrst_out_valid", 32'(out_valid), 32'h0);
    check_vec("midrst_out_data", out_data, 32'h0);
    check_vec("midrst_sel_err3", 32'(sel_err3), 32'h0);
    check_vec("midrst_out_valid3", 32'(out_valid3), 32'h0);
    @(negedge clk);
    rst = 1'b0;

    // Traffic resumes after reset
    in_valid  = 1'b1;
    in_data   = 8'h44;
    in_select = 2'd2;
    edge_sample();
    in_valid = 1'b0;
    check_vec("post_rst_valid", 32'(out_valid), 32'h4);
    check_vec("post_rst_data", out_data, 32'h00440000);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
